// File: rtl/tbl_lookup_rd.sv
// tbl_lookup_rd: read-side lookup engine for a synchronous table RAM.
// Takes tagged requests, drives RAM port B, absorbs the one-cycle read
// latency and returns tagged results through a two-entry output FIFO.
// A snoop of RAM port A gives write-first data on same-cycle collisions.
module tbl_lookup_rd #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 38,
    parameter int TAG_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,

    // request side
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [TAG_BITS-1:0]  req_tag,

    // RAM read port B
    output logic                 mem_enb,
    output logic [ADDR_BITS-1:0] mem_addrb,
    input  logic [DATA_BITS-1:0] mem_doutb,

    // snoop of RAM write port A
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,

    // response side
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic [TAG_BITS-1:0]  rsp_tag
);

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic [TAG_BITS-1:0]  tag;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // In-flight stage: one RAM read outstanding.
    logic                 inflight_q, inflight_d;
    logic                 byp_q,      byp_d;
    logic [TAG_BITS-1:0]  inf_tag_q,  inf_tag_d;
    logic [DATA_BITS-1:0] byp_data_q, byp_data_d;

    // Output FIFO.
    entry_t               fifo_q [DEPTH];
    entry_t               fifo_d [DEPTH];
    logic                 head_q,  head_d;
    logic                 tail_q,  tail_d;
    logic [1:0]           count_q, count_d;

    // ------------------------------------------------------------------
    // Handshake terms
    // ------------------------------------------------------------------
    logic       acc;
    logic       pop;
    logic       push;
    logic [1:0] occ;
    entry_t     push_entry;

    // Credit check and request/response handshakes.
    always_comb begin
        rsp_valid = (count_q != 2'd0);
        pop       = rsp_valid & rsp_ready;
        // Everything accepted but not yet popped: queued plus the read in flight.
        occ       = count_q + {1'b0, inflight_q};
        // A pop in this cycle frees a slot, so rsp_ready reaches req_ready
        // combinationally; this keeps one lookup per cycle under streaming.
        req_ready = !rst && ((occ - {1'b0, pop}) < 2'd2);
        acc       = req_valid & req_ready;
        mem_enb   = acc;
        mem_addrb = req_addr;
    end

    // Response outputs come straight from the FIFO head entry.
    always_comb begin
        rsp_data = fifo_q[head_q].data;
        rsp_tag  = fifo_q[head_q].tag;
    end

    // ------------------------------------------------------------------
    // In-flight stage
    // ------------------------------------------------------------------
    // Capture tag and collision information alongside the RAM read.
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned; otherwise a latch is inferred.
        inflight_d = acc;
        byp_d      = byp_q;
        inf_tag_d  = inf_tag_q;
        byp_data_d = byp_data_q;
        if (acc) begin
            // A write landing on the same address in the same cycle wins
            // over the RAM's read-first output.
            byp_d      = wr_en && (wr_addr == req_addr);
            inf_tag_d  = req_tag;
            byp_data_d = wr_data;
        end
    end

    // Select the returning entry: bypass data on collision, RAM data otherwise.
    always_comb begin
        push            = inflight_q;
        push_entry.data = byp_q ? byp_data_q : mem_doutb;
        push_entry.tag  = inf_tag_q;
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    // Pointer, count and storage updates for the two-entry FIFO.
    always_comb begin
        fifo_d = fifo_q;
        head_d = head_q;
        tail_d = tail_q;
        count_d = count_q;

        if (push) begin
            fifo_d[tail_q] = push_entry;
            tail_d         = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end

        // Push and pop together leave the count unchanged.
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Control state: cleared by reset, which discards any pending responses.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            inflight_q <= 1'b0;
            byp_q      <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            inflight_q <= inflight_d;
            byp_q      <= byp_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Data-path storage: only ever read when qualified by valid control state.
    always_ff @(posedge clk) begin
        // NOTE: payload storage is deliberately not reset; control state
        // guards every use, and leaving it out keeps reset fan-out small.
        inf_tag_q  <= inf_tag_d;
        byp_data_q <= byp_data_d;
        for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= fifo_d[i];
        end
    end

endmodule

// File: tb/tb_tbl_lookup_rd.sv
// tb_tbl_lookup_rd: directed and randomized checks of tbl_lookup_rd against
// a transaction-level model (expected-response queue plus table image).
module tb_tbl_lookup_rd;

    localparam int AB = 5;
    localparam int DB = 38;
    localparam int TB = 8;
    localparam int NENT = 1 << AB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AB-1:0] req_addr = '0;
    logic [TB-1:0] req_tag = '0;
    logic          mem_enb;
    logic [AB-1:0] mem_addrb;
    logic [DB-1:0] mem_doutb = '0;
    logic          wr_en = 1'b0;
    logic [AB-1:0] wr_addr = '0;
    logic [DB-1:0] wr_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DB-1:0] rsp_data;
    logic [TB-1:0] rsp_tag;

    tbl_lookup_rd #(.ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(TB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_tag   (req_tag),
        .mem_enb   (mem_enb),
        .mem_addrb (mem_addrb),
        .mem_doutb (mem_doutb),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag)
    );

    always #5 clk = ~clk;

    // Table RAM: port A write, port B read-first with one-cycle latency.
    logic [DB-1:0] ram [NENT];
    always @(posedge clk) begin
        if (wr_en)   ram[wr_addr] <= wr_data;
        if (mem_enb) mem_doutb    <= ram[mem_addrb];
    end

    // Reference model state.
    typedef struct {
        logic [DB-1:0] data;
        logic [TB-1:0] tag;
        int            acc_edge;
    } exp_t;

    logic [DB-1:0] model_ram [NENT];
    exp_t          q [$];
    int            edge_n = 0;
    int            n_acc = 0;
    int            n_pop = 0;
    logic [DB-1:0] last_data = '0;
    logic [TB-1:0] last_tag = '0;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs against
    // the model, then advance the model at the posedge.
    task automatic step(input logic rv, input logic [AB-1:0] ra, input logic [TB-1:0] rt,
                        input logic rr, input logic we, input logic [AB-1:0] wa,
                        input logic [DB-1:0] wd);
        logic exp_valid, exp_pop, exp_ready, exp_acc;
        exp_t ent;
        @(negedge clk);
        req_valid = rv; req_addr = ra; req_tag = rt; rsp_ready = rr;
        wr_en = we; wr_addr = wa; wr_data = wd;
        #1;
        // A response becomes visible one full cycle after its accept edge.
        exp_valid = !rst && (q.size() > 0) && (q[0].acc_edge < edge_n);
        exp_pop   = exp_valid && rr;
        exp_ready = !rst && ((q.size() - (exp_pop ? 1 : 0)) < 2);
        exp_acc   = rv && exp_ready;
        check("rsp_valid", rsp_valid, exp_valid);
        check("req_ready", req_ready, exp_ready);
        check("mem_enb", mem_enb, exp_acc);
        if (exp_acc) check("mem_addrb", mem_addrb, ra);
        if (exp_valid) begin
            check("rsp_data", rsp_data, q[0].data);
            check("rsp_tag", rsp_tag, q[0].tag);
        end
        if (exp_pop) begin
            last_data = rsp_data;
            last_tag  = rsp_tag;
        end
        check("occ_le_2", (int'(dut.count_q) + int'(dut.inflight_q)) <= 2, 1);
        @(posedge clk);
        edge_n++;
        if (exp_pop) begin
            void'(q.pop_front());
            n_pop++;
        end
        if (exp_acc) begin
            // Same-cycle write wins; any earlier write is already in the image.
            ent.data     = (we && (wa == ra)) ? wd : model_ram[ra];
            ent.tag      = rt;
            ent.acc_edge = edge_n;
            q.push_back(ent);
            n_acc++;
        end
        if (we) model_ram[wa] = wd;
    endtask

    task automatic idle(input int n, input logic rr);
        repeat (n) step(1'b0, '0, '0, rr, 1'b0, '0, '0);
    endtask

    task automatic write(input logic [AB-1:0] a, input logic [DB-1:0] d);
        step(1'b0, '0, '0, 1'b1, 1'b1, a, d);
    endtask

    initial begin
        logic [63:0] r64;
        int p0, a0;
        logic [AB-1:0] ra, wa;

        for (int i = 0; i < NENT; i++) begin
            r64 = {$urandom, $urandom};
            ram[i]       = r64[DB-1:0];
            model_ram[i] = r64[DB-1:0];
        end

        // Reset state: nothing accepted, nothing returned.
        req_valid = 1'b1;
        #2;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_mem_enb", mem_enb, 0);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // Single lookup.
        write(5'd3, 38'h2A_DEAD_BEEF);
        p0 = n_pop;
        step(1'b1, 5'd3, 8'h11, 1'b1, 1'b0, '0, '0);
        idle(4, 1'b1);
        check("single_count", n_pop - p0, 1);
        check("single_data", last_data, 38'h2A_DEAD_BEEF);
        check("single_tag", last_tag, 8'h11);

        // Streaming, including the top address.
        p0 = n_pop;
        step(1'b1, 5'd0,  8'd0, 1'b1, 1'b0, '0, '0);
        step(1'b1, 5'd1,  8'd1, 1'b1, 1'b0, '0, '0);
        step(1'b1, 5'd2,  8'd2, 1'b1, 1'b0, '0, '0);
        step(1'b1, 5'd31, 8'd3, 1'b1, 1'b0, '0, '0);
        idle(4, 1'b1);
        check("stream_count", n_pop - p0, 4);
        check("stream_last_data", last_data, model_ram[31]);
        check("stream_last_tag", last_tag, 8'd3);

        // Backpressure: two accepts, then stall; response held steady.
        a0 = n_acc;
        p0 = n_pop;
        for (int i = 0; i < 12; i++) step(1'b1, 5'(i), 8'(8'h40 + i), 1'b0, 1'b0, '0, '0);
        check("bp_accepts", n_acc - a0, 2);
        check("bp_no_pop", n_pop - p0, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 5'(i + 20), 8'(8'h60 + i), 1'b1, 1'b0, '0, '0);
        idle(4, 1'b1);
        check("bp_drain", n_pop - p0, n_acc - a0);

        // Collision bypass and late-write ordering.
        write(5'd5, 38'h1);
        step(1'b1, 5'd5, 8'h55, 1'b1, 1'b1, 5'd5, 38'h3F_0000_0005);
        idle(3, 1'b1);
        check("bypass_data", last_data, 38'h3F_0000_0005);
        check("bypass_tag", last_tag, 8'h55);
        write(5'd5, 38'h1);
        step(1'b1, 5'd5, 8'h56, 1'b1, 1'b0, '0, '0);
        write(5'd5, 38'h22_2222_2222);
        idle(3, 1'b1);
        check("late_write_data", last_data, 38'h1);
        check("late_write_tag", last_tag, 8'h56);

        // Reset mid-operation.
        step(1'b1, 5'd7, 8'h70, 1'b0, 1'b0, '0, '0);
        step(1'b1, 5'd8, 8'h71, 1'b0, 1'b0, '0, '0);
        idle(1, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_req_ready", req_ready, 0);
        q.delete();
        idle(2, 1'b1);
        #3 rst = 1'b0;
        p0 = n_pop;
        step(1'b1, 5'd9, 8'h99, 1'b1, 1'b0, '0, '0);
        idle(4, 1'b1);
        check("post_rst_count", n_pop - p0, 1);
        check("post_rst_tag", last_tag, 8'h99);

        // Random soak.
        for (int i = 0; i < 10000; i++) begin
            ra  = 5'($urandom_range(0, NENT - 1));
            wa  = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, NENT - 1));
            r64 = {$urandom, $urandom};
            step(1'($urandom_range(0, 3) != 0), ra, 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0),
                 wa, r64[DB-1:0]);
        end
        idle(4, 1'b1);
        check("soak_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tbl_lookup_rd.md
# tbl_lookup_rd

Read-side lookup engine for a `blk_mem_gen_2` table. It accepts tagged lookup requests on a valid/ready interface and drives the RAM read port (B). It absorbs the RAM's 1-cycle read latency and returns tagged results on a valid/ready interface with full backpressure. It sits between a pipeline stage's key/index logic and the table RAM. A snoop of the RAM write port (A) provides write-first bypass on same-cycle address collisions, so control-path table updates never return stale or undefined data.

## Interface
Parameters:
- `ADDR_BITS`, 5, table address width; must match the RAM instance.
- `DATA_BITS`, 38, table entry width; must match the RAM instance.
- `TAG_BITS`, 8, opaque request tag carried to the response.

Ports:
- `clk`  in  1  single clock for all logic; RAM `clka`/`clkb` are tied to this clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  lookup request valid.
- `req_ready`  out  1  request accepted when `req_valid & req_ready` is high at a rising edge.
- `req_addr`  in  ADDR_BITS  table index.
- `req_tag`  in  TAG_BITS  request tag.
- `mem_enb`  out  1  RAM port B enable.
- `mem_addrb`  out  ADDR_BITS  RAM port B address.
- `mem_doutb`  in  DATA_BITS  RAM port B data; valid in the cycle after `mem_enb`.
- `wr_en`  in  1  snoop of RAM `ena & wea`.
- `wr_addr`  in  ADDR_BITS  snoop of RAM `addra`.
- `wr_data`  in  DATA_BITS  snoop of RAM `dina`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready` is high at a rising edge.
- `rsp_data`  out  DATA_BITS  table entry.
- `rsp_tag`  out  TAG_BITS  tag of the originating request.

## Operation
- **Accept.** `acc = req_valid & req_ready`. `mem_enb = acc` and `mem_addrb = req_addr`, both combinational.
- **In-flight stage.** On `acc`, register `inflight<=1`, the tag, the collision flag `byp = wr_en & (wr_addr == req_addr)`, and `wr_data` into a bypass register. Otherwise `inflight<=0`.
- **Capture.** In the cycle where `inflight=1`, push `{byp ? byp_data : mem_doutb, tag}` into a 2-entry output FIFO at the next edge.
  - Writes to the same address in later cycles do not alter the captured data.
  - This gives read-then-write ordering for non-colliding cycles and write-first ordering for the same cycle.
- **Output FIFO.** Two entries, in-order, with head pointer, tail pointer and 2-bit count.
  - `rsp_valid = (count != 0)`; `rsp_data` and `rsp_tag` are driven from the head entry.
  - `pop = rsp_valid & rsp_ready`.
- **Credit.**
  - `occ = count + inflight`, range 0..2.
  - `req_ready = !rst & ((occ - pop) < 2)`.
  - `rsp_ready` has a combinational path to `req_ready`. This path is intentional, for full throughput.
- **Never-overflow invariant.** `occ <= 2` at all times. A push with `count==2` and no pop is impossible, and the bench asserts it.
- **Simultaneous events.** Push and pop in the same cycle leave count unchanged and advance both pointers.
- **Address range.** Addresses are used unmodified; no range check applies, and address `2^ADDR_BITS-1` is valid.

## Timing
- **Reset values:**
  - outputs: `rsp_valid=0`, `req_ready=0` while `rst` is high, `mem_enb=0`;
  - internal state: count=0, pointers=0, `inflight=0`;
  - data/tag outputs: don't-care, driven from entry 0.
- `req_ready=1` in the first cycle after `rst` deasserts.
- **Latency.** A request accepted at edge N gives `rsp_valid=1` during cycle N+2, i.e. after edge N+1.
- **Throughput.** One lookup per cycle when `rsp_ready` is held high.
- **Backpressure.** With `rsp_ready=0`, at most 2 requests are accepted; then `req_ready=0` until a pop.
- **Handshake rules.**
  - `rsp_valid`, `rsp_data` and `rsp_tag` stay stable while `rsp_valid & !rsp_ready`.
  - `req_*` inputs are sampled only on `acc`.
- **Reset mid-operation.** Asserting `rst` immediately discards in-flight and queued responses. No response for those requests is ever produced.

## Test plan
- **Single lookup.** Preload addr 3 = 0x2A_DEAD_BEEF, then request addr 3 with tag 0x11 at edge N. Required: `rsp_valid` in cycle N+2 with data 0x2A_DEAD_BEEF, tag 0x11, and exactly one response.
- **Streaming.** Requests to addrs 0,1,2,31 on back-to-back cycles, tags 0..3, `rsp_ready=1`. Required: four consecutive `rsp_valid` cycles starting at N+2, in order, with correct data including the wrap address 31.
- **Backpressure.** Hold `rsp_ready=0` with `req_valid=1` continuously. Required:
  - exactly 2 accepts, then `req_ready=0`;
  - `rsp` stable for 10 cycles;
  - after releasing `rsp_ready`: responses in order, accepts resume, no loss or duplication.
- **Collision bypass.** Addr 5 holds 0x1. In the same cycle, write 0x3F_0000_0005 to addr 5 and request addr 5. Required: response data 0x3F_0000_0005. A write to addr 5 one cycle after the request leaves the response at the old value.
- **Reset mid-operation.** Accept 2 requests with `rsp_ready=0`, then pulse `rst` asynchronously between edges. Required:
  - `rsp_valid=0` and `req_ready=0` immediately;
  - no stale responses after reset;
  - a new request afterwards returns in 2 cycles.
- **Random soak.** Random `req_valid`/`rsp_ready`/`wr_en` for 10k cycles against a reference model. Required: all responses match, and the occupancy assertion never fires.
